// File: rtl/pe_wb_collector.sv
// Write-back collector: accumulates PE group beats per output pixel,
// adds bias, requantizes, applies ReLU, saturates to int8, writes ofmap.
//
// Ports:
//   clk, rst (async active-low)
//   layer, start, pass_num, out_base, out_count,
//   bias, shift, relu_en          : job configuration
//   wb_en, groupsum_in1/2         : beat stream from the PE group
//   busy, done, overrun           : status
//   ofmap_we/addr/wdata           : ofmap buffer write port
module pe_wb_collector #(
    parameter int ADDR_W = 12,
    parameter int ACC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        layer,
    input  logic              start,
    input  logic [5:0]        pass_num,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W-1:0] out_count,
    input  logic [15:0]       bias,
    input  logic [3:0]        shift,
    input  logic              relu_en,
    input  logic              wb_en,
    input  logic [18:0]       groupsum_in1,
    input  logic [18:0]       groupsum_in2,
    output logic              busy,
    output logic              ofmap_we,
    output logic [ADDR_W-1:0] ofmap_addr,
    output logic [15:0]       ofmap_wdata,
    output logic              done,
    output logic              overrun
);

    localparam logic [3:0] LAYER5 = 4'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic signed [ACC_W:0] SAT_HI =
        (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] SAT_LO =
        -(ACC_W+1)'(128);

    logic [1:0]        state;
    logic [5:0]        cfg_pass;
    logic [ADDR_W-1:0] cfg_count;
    logic [15:0]       cfg_bias;
    logic [3:0]        cfg_shift;
    logic              cfg_relu;
    logic              cfg_two;

    logic [5:0]        beat_cnt;
    logic [ADDR_W-1:0] out_idx;
    logic [ADDR_W-1:0] next_addr;

    logic signed [ACC_W-1:0] acc0;
    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] s1_0;
    logic signed [ACC_W-1:0] s1_1;
    logic                    s1_valid;

    logic signed [ACC_W-1:0] beat0;
    logic signed [ACC_W-1:0] beat1;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [ACC_W-1:0] add0;
    logic signed [ACC_W-1:0] add1;
    logic                    last_beat;
    logic                    last_out;
    logic [7:0]              lane0;
    logic [7:0]              lane1;

    // Round-half-up arithmetic shift, optional ReLU, int8 clamp.
    // One extra bit of headroom keeps the rounding add exact.
    function automatic logic [7:0] post(
        input logic signed [ACC_W-1:0] s,
        input logic [3:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] x;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] r;
        x   = {s[ACC_W-1], s};
        rnd = '0;
        r   = x;
        if (sh != 4'd0) begin
            rnd = (ACC_W+1)'(1) << (sh - 4'd1);
            r   = (x + rnd) >>> sh;
        end
        if (relu && (r < 0))
            r = '0;
        if (r > SAT_HI)
            return 8'h7f;
        else if (r < SAT_LO)
            return 8'h80;
        else
            return r[7:0];
    endfunction

    always_comb begin
        beat0  = {{(ACC_W-19){groupsum_in1[18]}},
                  groupsum_in1};
        beat1  = {{(ACC_W-19){groupsum_in2[18]}},
                  groupsum_in2};
        bias_x = {{(ACC_W-16){cfg_bias[15]}},
                  cfg_bias};
        add0   = acc0 + beat0;
        add1   = acc1 + beat1;
        last_beat = (beat_cnt == cfg_pass - 6'd1);
        last_out  = (out_idx == cfg_count - ADDR_W'(1));
        lane0  = post(s1_0, cfg_shift, cfg_relu);
        lane1  = post(s1_1, cfg_shift, cfg_relu);
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cfg_pass    <= '0;
            cfg_count   <= '0;
            cfg_bias    <= '0;
            cfg_shift   <= '0;
            cfg_relu    <= 1'b0;
            cfg_two     <= 1'b0;
            beat_cnt    <= '0;
            out_idx     <= '0;
            next_addr   <= '0;
            acc0        <= '0;
            acc1        <= '0;
            s1_0        <= '0;
            s1_1        <= '0;
            s1_valid    <= 1'b0;
            ofmap_we    <= 1'b0;
            ofmap_addr  <= '0;
            ofmap_wdata <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done     <= 1'b0;
            ofmap_we <= 1'b0;
            s1_valid <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        cfg_pass  <= (pass_num == 6'd0) ?
                                     6'd1 : pass_num;
                        cfg_count <= (out_count == '0) ?
                                     ADDR_W'(1) : out_count;
                        cfg_bias  <= bias;
                        cfg_shift <= shift;
                        cfg_relu  <= relu_en;
                        cfg_two   <= (layer == LAYER5);
                        next_addr <= out_base;
                        beat_cnt  <= '0;
                        out_idx   <= '0;
                        acc0      <= '0;
                        acc1      <= '0;
                        // a beat arriving with start is dropped
                        overrun   <= wb_en;
                    end else if (wb_en) begin
                        overrun <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (wb_en) begin
                        if (last_beat) begin
                            s1_0     <= add0 + bias_x;
                            s1_1     <= add1 + bias_x;
                            s1_valid <= 1'b1;
                            acc0     <= '0;
                            acc1     <= '0;
                            beat_cnt <= '0;
                            out_idx  <= out_idx + ADDR_W'(1);
                            if (last_out)
                                state <= S_FLUSH;
                        end else begin
                            acc0     <= add0;
                            acc1     <= add1;
                            beat_cnt <= beat_cnt + 6'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (wb_en)
                        overrun <= 1'b1;
                    // final write is on the port once stage 1
                    // has drained and the strobe is high
                    if (!s1_valid && ofmap_we) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (s1_valid) begin
                ofmap_we    <= 1'b1;
                ofmap_addr  <= next_addr;
                ofmap_wdata <= {cfg_two ? lane1 : 8'h00,
                                lane0};
                next_addr   <= next_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: doc/pe_wb_collector.md
# pe_wb_collector

Write-back collector for the PE group datapath: it consumes the `groupsum` / `wb_en` beats a PE group produces and accumulates a fixed number of consecutive beats per output pixel. Per lane it then adds bias, requantizes with a rounding right shift, and optionally applies ReLU. It saturates each lane to int8 and writes the result into the ofmap buffer at an auto-incrementing address, raising `done` when the programmed number of outputs has been written. It sits between the PE group outputs and the ofmap SRAM write port, under control of the layer sequencer.

## Interface
- `ADDR_W`, 12: ofmap buffer address width.
- `ACC_W`, 26: accumulator width per lane. Must be ≥ 25 so that 63 beats × 19 bits plus bias never overflows.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low. Equals the project `RstEnable` level when asserted.
- `layer` in 4: layer code from the project defines.
  - `Layer5`: two-lane mode.
  - Any other code, including `Layer1`: single-lane mode.
- `start` in 1: one-cycle pulse that latches the configuration and begins a job. Ignored while `busy`.
- `pass_num` in 6: beats accumulated per output; 0 is treated as 1.
- `out_base` in ADDR_W: first write address.
- `out_count` in ADDR_W: number of outputs in the job; 0 is treated as 1.
- `bias` in 16: signed bias, added to each lane.
- `shift` in 4: requantize right shift, 0..15.
- `relu_en` in 1: clamp negative results to 0.
- `wb_en` in 1: beat valid.
- `groupsum_in1` in 19: signed lane-0 beat.
- `groupsum_in2` in 19: signed lane-1 beat, used only in `Layer5` mode.
- `busy` out 1: a job is active.
- `ofmap_we` out 1: write strobe.
- `ofmap_addr` out ADDR_W: write address.
- `ofmap_wdata` out 16: {lane1 int8, lane0 int8}. In single-lane mode the upper byte is 0.
- `done` out 1: one-cycle pulse after the final write.
- `overrun` out 1: sticky error flag; cleared by an accepted `start`.

## Operation
- Reset: all outputs and all internal state are 0, and the FSM enters IDLE. A reset mid-job aborts the job and leaves no pending write.
- FSM states:
  - IDLE → RUN on `start`. All configuration inputs are latched on that cycle, `busy` goes to 1, and `overrun` is cleared.
  - RUN → FLUSH when the beat that completes output number `out_count` is accepted.
  - FLUSH → IDLE once that output's write has issued; `done` pulses and `busy` drops.
- RUN:
  - Each `wb_en` beat adds the sign-extended beat into each lane accumulator (`acc`).
  - A beat counter counts beats toward the latched `pass_num`.
  - On the final beat of an output, `acc` + beat + bias is latched into a stage-1 register. `acc` and the beat counter clear on the same edge, so a beat on the very next cycle starts the next output with no bubble.
  - Configuration inputs are ignored outside the `start` cycle.
- Post-processing, stage 2, per lane, applied to the stage-1 value `s`:
  - Rounding: if `shift` > 0, `r = (s + (1 << (shift-1))) >>> shift`, an arithmetic shift with round-half-up. If `shift` = 0, `r = s`.
  - ReLU: if `relu_en` and `r` < 0, then `r = 0`.
  - Saturation: clamp `r` to [-128, 127] and take the low 8 bits.
- Write:
  - `ofmap_we` pulses for one cycle per output.
  - The first write goes to `out_base`. Each later write goes to the previous address + 1, wrapping modulo 2^ADDR_W.
- `wb_en` while in IDLE or FLUSH: the beat is discarded and `overrun` is set to 1.
- `start` and a `wb_en` beat in the same cycle in IDLE: the job starts, and that beat is discarded with `overrun` set.

## Timing
- Final beat of an output accepted at edge T:
  - Stage-1 register valid after T.
  - `ofmap_we`, `ofmap_addr` and `ofmap_wdata` are registered outputs, valid for the single cycle after edge T+1.
  - Total latency from final beat to write strobe: 2 cycles.
- Sustained throughput: with `pass_num` = 1 and `wb_en` held high, one write per cycle.
- `done` is asserted in the cycle after the last `ofmap_we` cycle, and `busy` is 0 from that same cycle.
- `ofmap_addr` and `ofmap_wdata` hold their last values when `ofmap_we` = 0.

## Test plan
- Single-lane rounding:
  - Stimulus: `Layer1`, `pass_num` 3, `bias` 10, `shift` 2, `relu_en` 1, `out_base` 0x010, `out_count` 1; beats 100, 200, -50.
  - Required: `ofmap_we` at T+2 with `ofmap_addr` 0x010 and `ofmap_wdata` 0x0041 (sum 260, rounded shift gives 65); `done` the next cycle.
- Saturation and ReLU (`shift` 0, `bias` 0, `pass_num` 1, `out_count` 3):
  - Beats 1000, -300, -300 with `relu_en` 1 → `ofmap_wdata` 0x007F then 0x0000.
  - Repeat with `relu_en` 0; the -300 beat → 0x0080.
- Two-lane mode:
  - Stimulus: `Layer5`, `pass_num` 1, `shift` 1, `bias` 0; `groupsum_in1` = -5, `groupsum_in2` = 40.
  - Required: `ofmap_wdata` 0x14FE (lane0 -2, lane1 20).
- Back-to-back with address wrap:
  - Stimulus: `pass_num` 1, `out_count` 4, `out_base` 0xFFE, `wb_en` high for 4 consecutive cycles.
  - Required: 4 consecutive `ofmap_we` cycles at addresses 0xFFE, 0xFFF, 0x000, 0x001; `done` exactly one cycle after the last strobe.
- Overrun:
  - A `wb_en` beat while in IDLE → `overrun` 1, no write issued.
  - A subsequent `start` → `overrun` 0.
- Reset mid-job:
  - Stimulus: `rst` low 2 cycles after the final beat of an output is accepted.
  - Required: `ofmap_we` never asserts, all outputs are 0, `busy` 0; a new job after reset produces correct values.
